fetch_unit: RTL and testbench

- IF-stage fetch controller and the consumer of the next-PC unit's `npc`/`boj` outputs.
- Holds the architectural PC and drives the instruction-memory request handshake.
- Keeps a one-entry skid buffer and loads the IF/ID pipeline register.
- Applies branch/jump redirects under the MIPS single-delay-slot rule: the instruction after a taken branch always executes, and the redirect is never lost across stalls or memory wait states.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if_id_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch controller: FSM encoding,
// reset/bubble constants and the PC alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_PEND  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

  // PC writes are always word aligned
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: loads a real instruction, loads a bubble
// (NOP, valid=0) or holds.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d
);

  // IF/ID state update; load takes priority over bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d    <= RESET_PC;
      instr_d <= NOP_WORD;
      valid_d <= 1'b0;
    end else if (load) begin
      pc_d    <= pc_in;
      instr_d <= instr_in;
      valid_d <= 1'b1;
    end else if (bubble) begin
      pc_d    <= pc_in;
      instr_d <= NOP_WORD;
      valid_d <= 1'b0;
    end else begin
      pc_d    <= pc_d;
      instr_d <= instr_d;
      valid_d <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage fetch controller: architectural PC, imem handshake, one-entry
// skid buffer and MIPS delay-slot redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        boj,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic [31:0] pc8_d
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  buf_pc_r, buf_pc_nxt_s;
  logic [31:0]  buf_instr_r, buf_instr_nxt_s;
  logic [31:0]  tgt_r, tgt_nxt_s;
  logic         adv_s, fire_s, redir_s;
  logic [31:0]  target_s, pc_inc_s;
  logic         ld_s, bub_s;
  logic [31:0]  ifid_pc_s, ifid_instr_s;

  assign imem_req  = !reset && (state_r != ST_FULL);
  assign imem_addr = pc_r;
  assign adv_s     = !stall;
  assign fire_s    = imem_req && imem_ready;
  // A branch only counts when it is a real instruction leaving ID
  assign redir_s   = boj && valid_d && adv_s;
  assign target_s  = align_pc(npc);
  assign pc_inc_s  = pc_r + 32'd4;
  assign pc8_d     = pc_d + 32'd8;

  // State, PC, skid buffer and saved target
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      pc_r        <= RESET_PC;
      buf_pc_r    <= 32'h0000_0000;
      buf_instr_r <= NOP_WORD;
      tgt_r       <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      buf_pc_r    <= buf_pc_nxt_s;
      buf_instr_r <= buf_instr_nxt_s;
      tgt_r       <= tgt_nxt_s;
    end
  end

  // Next-state and IF/ID control
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    buf_pc_nxt_s    = buf_pc_r;
    buf_instr_nxt_s = buf_instr_r;
    tgt_nxt_s       = tgt_r;
    ld_s            = 1'b0;
    bub_s           = 1'b0;
    ifid_pc_s       = pc_r;
    ifid_instr_s    = imem_rdata;
    case (state_r)
      ST_EMPTY: begin
        if (adv_s) begin
          if (fire_s) begin
            ld_s     = 1'b1;
            pc_nxt_s = redir_s ? target_s : pc_inc_s;
          end else begin
            bub_s = 1'b1;
            // Delay slot not fetched yet: remember where to go after it
            if (redir_s) begin
              tgt_nxt_s   = target_s;
              state_nxt_s = ST_PEND;
            end else begin
              state_nxt_s = ST_EMPTY;
            end
          end
        end else begin
          if (fire_s) begin
            buf_pc_nxt_s    = pc_r;
            buf_instr_nxt_s = imem_rdata;
            pc_nxt_s        = pc_inc_s;
            state_nxt_s     = ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
      end
      ST_FULL: begin
        if (adv_s) begin
          ld_s         = 1'b1;
          ifid_pc_s    = buf_pc_r;
          ifid_instr_s = buf_instr_r;
          pc_nxt_s     = redir_s ? target_s : pc_r;
          state_nxt_s  = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      ST_PEND: begin
        if (fire_s) begin
          pc_nxt_s = tgt_r;
          if (adv_s) begin
            ld_s        = 1'b1;
            state_nxt_s = ST_EMPTY;
          end else begin
            buf_pc_nxt_s    = pc_r;
            buf_instr_nxt_s = imem_rdata;
            state_nxt_s     = ST_FULL;
          end
        end else begin
          bub_s       = adv_s;
          state_nxt_s = ST_PEND;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ld_s),
    .bubble   (bub_s),
    .pc_in    (ifid_pc_s),
    .instr_in (ifid_instr_s),
    .pc_d     (pc_d),
    .instr_d  (instr_d),
    .valid_d  (valid_d)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; memory returns ~address as the
// instruction word so every fetched word is predictable.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        boj;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic [31:0] pc8_d;

  int n_cmp;
  int n_bad;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .boj        (boj),
    .npc        (npc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .valid_d    (valid_d),
    .pc8_d      (pc8_d)
  );

  assign imem_rdata = ~imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check the IF/ID contents for a real instruction fetched from pc
  task automatic check_id(input string tag, input logic [31:0] pc);
    check({tag, ".pc_d"}, pc_d, pc);
    check({tag, ".instr_d"}, instr_d, ~pc);
    check({tag, ".valid_d"}, {31'd0, valid_d}, 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    stall      = 1'b0;
    boj        = 1'b0;
    npc        = 32'h0000_0000;
    imem_ready = 1'b1;
    tick();
    tick();
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.valid_d", {31'd0, valid_d}, 32'd0);
    check("rst.pc_d", pc_d, 32'h0000_3000);
    check("rst.instr_d", instr_d, 32'h0000_0000);
    check("rst.addr", imem_addr, 32'h0000_3000);
    reset = 1'b0;
    #1;
    check("run.req", {31'd0, imem_req}, 32'd1);

    // Streaming, zero-wait memory
    tick();
    check("s1.addr", imem_addr, 32'h0000_3004);
    check_id("s1", 32'h0000_3000);
    check("s1.pc8", pc8_d, 32'h0000_3008);
    tick();
    check("s2.addr", imem_addr, 32'h0000_3008);
    check_id("s2", 32'h0000_3004);
    tick();
    check("s3.addr", imem_addr, 32'h0000_300C);
    check_id("s3", 32'h0000_3008);

    // Branch at 3008: delay slot 300C executes, then 3100
    boj = 1'b1; npc = 32'h0000_3100;
    tick();
    boj = 1'b0;
    check_id("br1.slot", 32'h0000_300C);
    check("br1.addr", imem_addr, 32'h0000_3100);
    tick();
    check_id("br1.tgt", 32'h0000_3100);
    check("br1.addr2", imem_addr, 32'h0000_3104);

    // Stall while fetch of 3104 fires -> buffer full, request dropped
    stall = 1'b1;
    tick();
    check("st.req", {31'd0, imem_req}, 32'd0);
    check("st.addr", imem_addr, 32'h0000_3108);
    check("st.pc_d", pc_d, 32'h0000_3100);
    tick();
    check("st2.req", {31'd0, imem_req}, 32'd0);
    check("st2.pc_d", pc_d, 32'h0000_3100);
    tick();
    check("st3.pc_d", pc_d, 32'h0000_3100);
    // Release with branch: buffered 3104 is the delay slot
    stall = 1'b0; boj = 1'b1; npc = 32'h0000_3200;
    tick();
    boj = 1'b0;
    check_id("fb.slot", 32'h0000_3104);
    check("fb.addr", imem_addr, 32'h0000_3200);
    check("fb.req", {31'd0, imem_req}, 32'd1);
    tick();
    check_id("fb.tgt", 32'h0000_3200);

    // Branch while memory waits at 3204 -> PEND
    imem_ready = 1'b0; boj = 1'b1; npc = 32'h0000_3300;
    tick();
    check("pd.valid_d", {31'd0, valid_d}, 32'd0);
    check("pd.instr_d", instr_d, 32'h0000_0000);
    check("pd.addr", imem_addr, 32'h0000_3204);
    // boj with valid_d=0 must be ignored
    npc = 32'h0000_3400;
    tick();
    boj = 1'b0;
    check("pd2.valid_d", {31'd0, valid_d}, 32'd0);
    check("pd2.addr", imem_addr, 32'h0000_3204);
    imem_ready = 1'b1;
    tick();
    check_id("pd.slot", 32'h0000_3204);
    check("pd.tgt_addr", imem_addr, 32'h0000_3300);
    tick();
    check_id("pd.tgt", 32'h0000_3300);

    // boj together with stall is ignored
    stall = 1'b1; boj = 1'b1; npc = 32'h0000_3500;
    tick();
    stall = 1'b0; boj = 1'b0;
    check("sb.addr", imem_addr, 32'h0000_3308);
    tick();
    check_id("sb.id", 32'h0000_3304);
    check("sb.addr2", imem_addr, 32'h0000_3308);

    // Misaligned target has its low bits cleared
    boj = 1'b1; npc = 32'h0000_3603;
    tick();
    boj = 1'b0;
    check("al.addr", imem_addr, 32'h0000_3600);
    tick();
    check_id("al.tgt", 32'h0000_3600);

    // Reset in the middle of PEND
    imem_ready = 1'b0; boj = 1'b1; npc = 32'h0000_3700;
    tick();
    boj = 1'b0;
    check("rp.valid_d", {31'd0, valid_d}, 32'd0);
    reset = 1'b1;
    #1;
    check("rp.req", {31'd0, imem_req}, 32'd0);
    tick();
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    check("rp.addr", imem_addr, 32'h0000_3000);
    check("rp.valid_d", {31'd0, valid_d}, 32'd0);
    check("rp.req2", {31'd0, imem_req}, 32'd1);
    tick();
    check_id("rp.first", 32'h0000_3000);
    check("rp.addr2", imem_addr, 32'h0000_3004);

    // Reset in the middle of FULL
    stall = 1'b1;
    tick();
    check("rf.req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1; stall = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rf.addr", imem_addr, 32'h0000_3000);
    check("rf.valid_d", {31'd0, valid_d}, 32'd0);
    check("rf.req2", {31'd0, imem_req}, 32'd1);
    tick();
    check_id("rf.first", 32'h0000_3000);
    check("rf.addr2", imem_addr, 32'h0000_3004);

    // PC wrap at the top of the address space
    boj = 1'b1; npc = 32'hFFFF_FFFC;
    tick();
    boj = 1'b0;
    check("wr.addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr.addr2", imem_addr, 32'h0000_0000);
    check_id("wr.top", 32'hFFFF_FFFC);
    check("wr.pc8", pc8_d, 32'h0000_0004);
    tick();
    check_id("wr.zero", 32'h0000_0000);
    check("wr.addr3", imem_addr, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
